uart_rx_fifo: RTL

Receive buffer placed directly downstream of the UART receiver. It captures each received byte from the receiver's valid/data output into a circular buffer and presents the bytes to the system side on a first-word-fall-through ready/valid stream. It also keeps a sticky overflow flag and a saturating framing-error counter. Because the receiver holds its valid level high until the next start bit, the write side is edge-qualified: one byte is written per valid assertion.

---
 rtl/uart_rx_fifo.sv | 116 +++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: edge-qualified UART receive buffer with FWFT stream output,
// sticky overflow flag and saturating receive-error counter.
module uart_rx_fifo #(
   parameter int DATA_W     = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [DATA_W-1:0]     i_data,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic                  i_rx_err,
   output logic [DATA_W-1:0]     o_data,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [DEPTH_LOG2:0]   o_level,
   output logic                  o_full,
   output logic                  o_empty,
   output logic                  o_overflow,
   output logic [7:0]            o_err_count,
   input  logic                  i_flush,
   input  logic                  i_clr_status
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
   localparam logic [DEPTH_LOG2:0]   LVL_ONE = 1;

   logic [DATA_W-1:0]     r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_level;
   logic                  r_valid_d;
   logic                  r_err_d;
   logic                  r_overflow;
   logic [7:0]            r_err_count;

   logic w_wr_req;
   logic w_err_evt;
   logic w_full;
   logic w_empty;
   logic w_wr_ok;
   logic w_pop;
   logic w_ovf_evt;

   // Level is never above DEPTH, so its top bit alone marks full.
   assign w_full    = r_level[DEPTH_LOG2];
   assign w_empty   = (r_level == '0);
   assign w_wr_req  = i_valid & ~r_valid_d;
   assign w_err_evt = i_rx_err & ~r_err_d;
   assign w_wr_ok   = w_wr_req & ~w_full;
   assign w_ovf_evt = w_wr_req & w_full;
   assign w_pop     = ~w_empty & i_ready;

   assign o_data      = r_mem[r_rd_ptr];
   assign o_valid     = ~w_empty;
   assign o_ready     = ~w_full;
   assign o_full      = w_full;
   assign o_empty     = w_empty;
   assign o_level     = r_level;
   assign o_overflow  = r_overflow;
   assign o_err_count = r_err_count;

   // Storage array; contents are not reset, flush suppresses the write.
   always_ff @(posedge i_clk) begin
      if (w_wr_ok && !i_flush) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Previous-cycle copies of the level inputs for edge detection.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid_d <= 1'b0;
         r_err_d   <= 1'b0;
      end else begin
         r_valid_d <= i_valid;
         r_err_d   <= i_rx_err;
      end
   end

   // Pointers and occupancy; flush wins over write and pop.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_wr_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_ONE;
         if (w_wr_ok && !w_pop)      r_level <= r_level + LVL_ONE;
         else if (!w_wr_ok && w_pop) r_level <= r_level - LVL_ONE;
      end
   end

   // Sticky overflow and saturating error count; new events beat clear.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_overflow  <= 1'b0;
         r_err_count <= 8'd0;
      end else begin
         if (w_ovf_evt)         r_overflow <= 1'b1;
         else if (i_clr_status) r_overflow <= 1'b0;
         if (i_clr_status) begin
            r_err_count <= w_err_evt ? 8'd1 : 8'd0;
         end else if (w_err_evt && r_err_count != 8'hFF) begin
            r_err_count <= r_err_count + 8'd1;
         end
      end
   end

endmodule
